// File: rtl/stw_time_core.sv
// Stopwatch / countdown timer core: IDLE/RUN/PAUSE/DONE control over an h:m:s counter.
// Optional lap capture is built only when STW_LAP_EN is defined.
module stw_time_core #(
  parameter int unsigned W       = 8,
  parameter int unsigned SEC_MOD = 60,
  parameter int unsigned MIN_MOD = 60,
  parameter int unsigned HR_MOD  = 24
) (
  input  logic         CLK,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         start,
  input  logic         stop,
  input  logic         clear,
  input  logic         mode,
  input  logic         load,
  input  logic [W-1:0] load_sec,
  input  logic [W-1:0] load_min,
  input  logic [W-1:0] load_hr,
  input  logic         lap,
  output logic [W-1:0] secs,
  output logic [W-1:0] mins,
  output logic [W-1:0] hrs,
  output logic [W-1:0] lap_secs,
  output logic [W-1:0] lap_mins,
  output logic [W-1:0] lap_hrs,
  output logic         lap_valid,
  output logic         running,
  output logic         wrap,
  output logic         done
);

  localparam logic [W-1:0] SecMax = W'(SEC_MOD - 1);
  localparam logic [W-1:0] MinMax = W'(MIN_MOD - 1);
  localparam logic [W-1:0] HrMax  = W'(HR_MOD - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e       r_state, w_state_d;
  logic         r_mode, w_mode_d;
  logic [W-1:0] r_secs, r_mins, r_hrs;
  logic [W-1:0] w_secs_d, w_mins_d, w_hrs_d;
  logic         r_wrap, w_wrap_d;
  logic         r_running, w_running_d;
  logic         r_done, w_done_d;

  logic [W-1:0] w_up_secs, w_up_mins, w_up_hrs;
  logic [W-1:0] w_dn_secs, w_dn_mins, w_dn_hrs;
  logic         w_up_wrap, w_dn_zero, w_zero;

  // Increment / decrement candidates with carry and borrow chains.
  always_comb begin
    w_up_secs = (r_secs == SecMax) ? '0 : r_secs + 1'b1;
    w_up_mins = r_mins;
    w_up_hrs  = r_hrs;
    if (r_secs == SecMax) begin
      w_up_mins = (r_mins == MinMax) ? '0 : r_mins + 1'b1;
      if (r_mins == MinMax) w_up_hrs = (r_hrs == HrMax) ? '0 : r_hrs + 1'b1;
    end
    w_up_wrap = (r_secs == SecMax) && (r_mins == MinMax) && (r_hrs == HrMax);

    w_dn_secs = (r_secs == '0) ? SecMax : r_secs - 1'b1;
    w_dn_mins = r_mins;
    w_dn_hrs  = r_hrs;
    if (r_secs == '0) begin
      w_dn_mins = (r_mins == '0) ? MinMax : r_mins - 1'b1;
      if (r_mins == '0) w_dn_hrs = (r_hrs == '0) ? HrMax : r_hrs - 1'b1;
    end
    w_dn_zero = (r_hrs == '0) && (r_mins == '0) && (r_secs == W'(1));
    w_zero    = (r_hrs == '0) && (r_mins == '0) && (r_secs == '0);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    if (clear) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle, StPause: begin
          if (!load && !stop && start) w_state_d = (mode && w_zero) ? StDone : StRun;
        end
        StRun: begin
          if (tick && r_mode && w_dn_zero) w_state_d = StDone;
          else if (stop)                   w_state_d = StPause;
        end
        StDone:  w_state_d = StDone;
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    w_mode_d = r_mode;
    w_secs_d = r_secs;
    w_mins_d = r_mins;
    w_hrs_d  = r_hrs;
    w_wrap_d = 1'b0;
    if (clear) begin
      w_secs_d = '0;
      w_mins_d = '0;
      w_hrs_d  = '0;
    end else begin
      unique case (r_state)
        StIdle, StPause: begin
          if (load) begin
            w_secs_d = (load_sec > SecMax) ? SecMax : load_sec;
            w_mins_d = (load_min > MinMax) ? MinMax : load_min;
            w_hrs_d  = (load_hr  > HrMax)  ? HrMax  : load_hr;
          end else if (!stop && start) begin
            w_mode_d = mode;
          end
        end
        StRun: begin
          // A tick coincident with stop still counts; the state is still RUN.
          if (tick) begin
            if (r_mode) begin
              w_secs_d = w_dn_secs;
              w_mins_d = w_dn_mins;
              w_hrs_d  = w_dn_hrs;
            end else begin
              w_secs_d = w_up_secs;
              w_mins_d = w_up_mins;
              w_hrs_d  = w_up_hrs;
              w_wrap_d = w_up_wrap;
            end
          end
        end
        default: ;
      endcase
    end
    w_running_d = (w_state_d == StRun);
    w_done_d    = (w_state_d == StDone);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_mode    <= 1'b0;
      r_secs    <= '0;
      r_mins    <= '0;
      r_hrs     <= '0;
      r_wrap    <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_mode    <= w_mode_d;
      r_secs    <= w_secs_d;
      r_mins    <= w_mins_d;
      r_hrs     <= w_hrs_d;
      r_wrap    <= w_wrap_d;
      r_running <= w_running_d;
      r_done    <= w_done_d;
    end
  end

  assign secs    = r_secs;
  assign mins    = r_mins;
  assign hrs     = r_hrs;
  assign wrap    = r_wrap;
  assign running = r_running;
  assign done    = r_done;

`ifdef STW_LAP_EN
  logic [W-1:0] r_lap_secs, r_lap_mins, r_lap_hrs;
  logic         r_lap_valid;

  // Captures the value present before this edge's tick update.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_lap_secs  <= '0;
      r_lap_mins  <= '0;
      r_lap_hrs   <= '0;
      r_lap_valid <= 1'b0;
    end else if (clear) begin
      r_lap_secs  <= '0;
      r_lap_mins  <= '0;
      r_lap_hrs   <= '0;
      r_lap_valid <= 1'b0;
    end else if (lap && (r_state == StRun || r_state == StPause)) begin
      r_lap_secs  <= r_secs;
      r_lap_mins  <= r_mins;
      r_lap_hrs   <= r_hrs;
      r_lap_valid <= 1'b1;
    end
  end

  assign lap_secs  = r_lap_secs;
  assign lap_mins  = r_lap_mins;
  assign lap_hrs   = r_lap_hrs;
  assign lap_valid = r_lap_valid;
`else
  logic w_unused_lap;
  assign w_unused_lap = lap;

  assign lap_secs  = '0;
  assign lap_mins  = '0;
  assign lap_hrs   = '0;
  assign lap_valid = 1'b0;
`endif

endmodule

// File: tb/tb_stw_time_core.sv
// Scoreboard bench for stw_time_core: expectations queued per driven cycle, popped after the edge.
module tb_stw_time_core;
  localparam int unsigned W = 8;

  logic         CLK = 1'b0;
  logic         rst_n = 1'b0;
  logic         tick = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, mode = 1'b0;
  logic         load = 1'b0, lap = 1'b0;
  logic [W-1:0] load_sec = '0, load_min = '0, load_hr = '0;
  logic [W-1:0] secs, mins, hrs, lap_secs, lap_mins, lap_hrs;
  logic         lap_valid, running, wrap, done;

  stw_time_core #(.W(W), .SEC_MOD(60), .MIN_MOD(60), .HR_MOD(24)) u_dut (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .tick      (tick),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .mode      (mode),
    .load      (load),
    .load_sec  (load_sec),
    .load_min  (load_min),
    .load_hr   (load_hr),
    .lap       (lap),
    .secs      (secs),
    .mins      (mins),
    .hrs       (hrs),
    .lap_secs  (lap_secs),
    .lap_mins  (lap_mins),
    .lap_hrs   (lap_hrs),
    .lap_valid (lap_valid),
    .running   (running),
    .wrap      (wrap),
    .done      (done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string tag;
    int    h, m, s;
    bit    run, dn, wr;
    int    lh, lm, ls;
    bit    lv;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   e_lh = 0, e_lm = 0, e_ls = 0;
  bit   e_lv = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int h, input int m, input int s,
                         input bit run, input bit dn, input bit wr);
    exp_t e;
    e.tag = tag; e.h = h; e.m = m; e.s = s;
    e.run = run; e.dn = dn; e.wr = wr;
    e.lh = e_lh; e.lm = e_lm; e.ls = e_ls; e.lv = e_lv;
    sb_q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", sb_q.size(), 1);
      return;
    end
    e = sb_q.pop_front();
    check_val({e.tag, ".secs"},      secs,      e.s);
    check_val({e.tag, ".mins"},      mins,      e.m);
    check_val({e.tag, ".hrs"},       hrs,       e.h);
    check_val({e.tag, ".running"},   running,   e.run);
    check_val({e.tag, ".done"},      done,      e.dn);
    check_val({e.tag, ".wrap"},      wrap,      e.wr);
    check_val({e.tag, ".lap_secs"},  lap_secs,  e.ls);
    check_val({e.tag, ".lap_mins"},  lap_mins,  e.lm);
    check_val({e.tag, ".lap_hrs"},   lap_hrs,   e.lh);
    check_val({e.tag, ".lap_valid"}, lap_valid, e.lv);
  endtask

  // One clock: queue the expectation for the driven inputs, sample 1 ns after the edge.
  task automatic step(input string tag, input int h, input int m, input int s,
                      input bit run, input bit dn, input bit wr);
    sb_push(tag, h, m, s, run, dn, wr);
    @(posedge CLK);
    #1;
    sb_check();
  endtask

  initial begin
    #12;
    sb_push("reset", 0, 0, 0, 0, 0, 0);
    sb_check();
    @(negedge CLK);
    rst_n = 1'b1;

    // Up count with minute carry.
    mode = 1'b0; start = 1'b1;
    step("start_up", 0, 0, 0, 1, 0, 0);
    start = 1'b0; tick = 1'b1;
    for (int i = 1; i <= 61; i++) step("up_cnt", 0, i / 60, i % 60, 1, 0, 0);
    tick = 1'b0;
    clear = 1'b1; step("clear1", 0, 0, 0, 0, 0, 0); clear = 1'b0;

    // Full rollover pulses wrap once and keeps running.
    load = 1'b1; load_hr = 8'd23; load_min = 8'd59; load_sec = 8'd58;
    step("load_max", 23, 59, 58, 0, 0, 0);
    load = 1'b0; start = 1'b1;
    step("start_wrap", 23, 59, 58, 1, 0, 0);
    start = 1'b0; tick = 1'b1;
    step("pre_wrap", 23, 59, 59, 1, 0, 0);
    step("wrap", 0, 0, 0, 1, 0, 1);
    tick = 1'b0;
    step("wrap_end", 0, 0, 0, 1, 0, 0);
    clear = 1'b1; step("clear2", 0, 0, 0, 0, 0, 0); clear = 1'b0;

    // Countdown with borrow, DONE and its hold behaviour.
    load = 1'b1; load_hr = 8'd0; load_min = 8'd1; load_sec = 8'd2;
    step("load_dn", 0, 1, 2, 0, 0, 0);
    load = 1'b0; mode = 1'b1; start = 1'b1;
    step("start_dn", 0, 1, 2, 1, 0, 0);
    start = 1'b0; mode = 1'b0; tick = 1'b1;
    step("dn1", 0, 1, 1, 1, 0, 0);
    step("dn2", 0, 1, 0, 1, 0, 0);
    step("borrow", 0, 0, 59, 1, 0, 0);
    for (int i = 0; i < 58; i++) step("dn_cnt", 0, 0, 58 - i, 1, 0, 0);
    step("dn_done", 0, 0, 0, 0, 1, 0);
    start = 1'b1;
    step("done_hold", 0, 0, 0, 0, 1, 0);
    start = 1'b0; tick = 1'b0;
    load = 1'b1; load_hr = 8'd5; load_min = 8'd5; load_sec = 8'd5;
    step("done_load", 0, 0, 0, 0, 1, 0);
    load = 1'b0;
    clear = 1'b1; step("clear_done", 0, 0, 0, 0, 0, 0); clear = 1'b0;
    mode = 1'b1; start = 1'b1;
    step("start_zero_dn", 0, 0, 0, 0, 1, 0);
    start = 1'b0; mode = 1'b0;
    clear = 1'b1; step("clear3", 0, 0, 0, 0, 0, 0); clear = 1'b0;

    // Stop with coincident tick, pause hold, resume with uncounted tick.
    start = 1'b1; step("start_p", 0, 0, 0, 1, 0, 0); start = 1'b0;
    tick = 1'b1;
    for (int i = 1; i <= 5; i++) step("run_p", 0, 0, i, 1, 0, 0);
    stop = 1'b1; step("stop_tick", 0, 0, 6, 0, 0, 0); stop = 1'b0;
    for (int i = 0; i < 3; i++) step("paused", 0, 0, 6, 0, 0, 0);
    start = 1'b1; step("resume_tick", 0, 0, 6, 1, 0, 0); start = 1'b0;
    step("resumed", 0, 0, 7, 1, 0, 0);
    tick = 1'b0;

    // Load saturation in PAUSE, priority of stop over start, load ignored in RUN.
    stop = 1'b1; step("stop2", 0, 0, 7, 0, 0, 0); stop = 1'b0;
    load = 1'b1; load_hr = 8'd0; load_min = 8'd75; load_sec = 8'd99;
    step("load_sat", 0, 59, 59, 0, 0, 0);
    load_hr = 8'd200; load_min = 8'd3; load_sec = 8'd60;
    step("load_sat_hr", 23, 3, 59, 0, 0, 0);
    load = 1'b0; stop = 1'b1; start = 1'b1;
    step("stop_over_start", 23, 3, 59, 0, 0, 0);
    stop = 1'b0;
    step("start3", 23, 3, 59, 1, 0, 0);
    start = 1'b0;
    load = 1'b1; load_hr = 8'd1; load_min = 8'd2; load_sec = 8'd3;
    step("load_in_run", 23, 3, 59, 1, 0, 0);
    load = 1'b0;
    clear = 1'b1; step("clear4", 0, 0, 0, 0, 0, 0); clear = 1'b0;

    // Lap capture with a coincident tick.
    start = 1'b1; step("start_lap", 0, 0, 0, 1, 0, 0); start = 1'b0;
    tick = 1'b1;
    for (int i = 1; i <= 10; i++) step("run_lap", 0, 0, i, 1, 0, 0);
    lap = 1'b1;
`ifdef STW_LAP_EN
    e_ls = 10; e_lv = 1'b1;
`endif
    step("lap", 0, 0, 11, 1, 0, 0);
    lap = 1'b0; tick = 1'b0;
    step("lap_hold", 0, 0, 11, 1, 0, 0);
    clear = 1'b1;
    e_lh = 0; e_lm = 0; e_ls = 0; e_lv = 1'b0;
    step("clear_lap", 0, 0, 0, 0, 0, 0);
    clear = 1'b0; lap = 1'b1;
    step("lap_idle", 0, 0, 0, 0, 0, 0);
    lap = 1'b0;

    // Asynchronous reset in the middle of RUN.
    start = 1'b1; step("start_rst", 0, 0, 0, 1, 0, 0); start = 1'b0;
    tick = 1'b1;
    for (int i = 1; i <= 3; i++) step("run_rst", 0, 0, i, 1, 0, 0);
    rst_n = 1'b0;
    #1;
    sb_push("async_rst", 0, 0, 0, 0, 0, 0);
    sb_check();
    tick = 1'b0;
    @(negedge CLK);
    rst_n = 1'b1;
    step("post_rst", 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stw_time_core.md
STW_TIME_CORE -- requirements
Module: stw_time_core

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  W        8   width of each time field
  SEC_MOD  60  seconds modulus
  MIN_MOD  60  minutes modulus
  HR_MOD   24  hours modulus
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  CLK       in   1   clock, rising edge
  rst_n     in   1   asynchronous, active-low reset
  tick      in   1   one-cycle count enable (1 Hz strobe)
  start     in   1   run / resume request
  stop      in   1   pause request (holds value, does not clear)
  clear     in   1   synchronous clear to IDLE
  mode      in   1   0 = count up (stopwatch), 1 = count down (timer)
  load      in   1   preset strobe
  load_sec  in   W   preset seconds
  load_min  in   W   preset minutes
  load_hr   in   W   preset hours
  lap       in   1   lap capture strobe
  secs      out  W   seconds field
  mins      out  W   minutes field
  hrs       out  W   hours field
  lap_secs  out  W   captured seconds
  lap_mins  out  W   captured minutes
  lap_hrs   out  W   captured hours
  lap_valid out  1   lap registers hold a capture
  running   out  1   state == RUN
  wrap      out  1   one-cycle pulse on up-mode full rollover
  done      out  1   level, state == DONE

Function
REQ-003 The FSM SHALL have the states IDLE, RUN, PAUSE and DONE.
REQ-004 Control priority SHALL be clear > load > stop > start, evaluated per cycle.
REQ-005 clear SHALL, from any state, zero secs/mins/hrs, lap registers and lap_valid, and enter IDLE.
REQ-006 load SHALL act only in IDLE or PAUSE and SHALL be ignored in RUN and DONE.
REQ-007 A load_x value at or above its modulus SHALL saturate to modulus-1.
REQ-008 start in IDLE or PAUSE SHALL enter RUN and latch mode; mode changes during RUN SHALL be ignored.
REQ-009 start in IDLE or PAUSE with mode=1 and all fields zero SHALL enter DONE directly.
REQ-010 stop in RUN SHALL enter PAUSE; stop in any other state SHALL have no effect.
REQ-011 tick SHALL be counted only when the registered state is RUN, so a tick coincident with start is not counted and a tick coincident with stop is counted.
REQ-012 Up mode: secs SHALL increment; at SEC_MOD-1 it SHALL wrap to 0 and carry into mins; likewise mins to hrs; hrs SHALL wrap at HR_MOD-1.
REQ-013 Up mode: the tick that rolls over from HR_MOD-1:MIN_MOD-1:SEC_MOD-1 to 0:0:0 SHALL assert wrap for exactly one cycle, and RUN SHALL continue.
REQ-014 Down mode: secs SHALL decrement; at 0 it SHALL reload SEC_MOD-1 and borrow from mins; likewise mins from hrs.
REQ-015 Down mode: the tick that reaches 0:0:0 SHALL enter DONE on the same edge; the fields SHALL hold 0 and done SHALL stay high until clear.
REQ-016 In DONE, tick, start, stop and load SHALL be ignored.
REQ-017 All outputs SHALL be registered, and field updates SHALL appear one cycle after the qualifying tick.
REQ-018 running SHALL be 1 exactly while the state is RUN.

Reset
REQ-019 rst_n low SHALL asynchronously force IDLE, all fields 0, all lap outputs 0, and running, wrap and done to 0.
REQ-020 Reset deassertion SHALL be synchronised by the integrator; the block SHALL take no action until the first CLK edge after release.

Configuration
REQ-021 Macro STW_LAP_EN defined: lap in RUN or PAUSE SHALL copy the pre-update secs/mins/hrs into the lap registers and set lap_valid; lap in IDLE or DONE SHALL be ignored.
REQ-022 Macro STW_LAP_EN undefined: the lap input SHALL be ignored, and lap_secs, lap_mins, lap_hrs and lap_valid SHALL be constant 0, with no lap storage inferred.

Verification
REQ-023 Reset, start, then 61 ticks in up mode -> mins=1, secs=1, running=1, wrap=0.
REQ-024 load 23:59:58 in IDLE, start in up mode, 2 ticks -> 0:0:0, wrap high for exactly 1 cycle, state stays RUN.
REQ-025 load 0:1:2, start with mode=1, 62 ticks -> 0:0:0, done=1, running=0; a further tick and start change nothing; clear -> IDLE, done=0.
REQ-026 RUN with stop and tick asserted together at 0:0:5 -> 0:0:6 and PAUSE; further ticks hold 0:0:6; start -> resumes counting.
REQ-027 Lap (STW_LAP_EN) at 0:0:10 with a coincident tick -> lap=0:0:10, fields=0:0:11, lap_valid=1; macro undefined -> lap outputs stay 0.
REQ-028 load 0:75:99 in PAUSE -> 0:59:59; load in RUN -> ignored; rst_n low mid-RUN -> all outputs 0 immediately, without waiting for a clock edge.
